mem_copy_initiator: RTL

- Bus initiator on the native valid/ready memory interface (valid, ready, addr, wdata, wstrb, rdata); the initiator side of the protocol that our memory responders implement.
- Copies a block of 32-bit words from a source address to a destination address: one read, then one write, per word.
- Used for SRAM-to-SRAM block moves and for loading coil waveform tables without CPU involvement.
- Sits beside the CPU on the shared bus, behind the existing arbiter.

---
 rtl/mem_bus_pkg.sv | 24 ++
 rtl/mem_req_timer.sv | 28 ++
 rtl/mem_copy_initiator.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for native valid/ready bus initiators.
// Holds the copy-engine state encoding, strobe constants and address helpers.
package mem_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_GAP_R  = 3'd2,
        ST_WR     = 3'd3,
        ST_GAP_W  = 3'd4,
        ST_FINISH = 3'd5
    } state_e;

    localparam logic [3:0] WSTRB_READ = 4'b0000;
    localparam logic [3:0] WSTRB_WORD = 4'b1111;

    localparam logic [31:0] WORD_BYTES = 32'd4;

    // Byte addresses are forced onto a word boundary; low bits are don't-care.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/mem_req_timer.sv
// Loadable down-counter for bus request timeouts.
// expired_o is high once the count has run down to zero.
module mem_req_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expired_o
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load_i) begin
            r_count <= load_val_i;
        end else if (en_i && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign expired_o = (r_count == '0);

endmodule

// File: rtl/mem_copy_initiator.sv
// Block copy engine: reads a word, then writes it, for len words, on the native bus.
// All bus outputs are registered; valid always drops for a cycle after each ready.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for start_i; latches src/dst/len
// ST_RD     | read request outstanding at src + 4*i
// ST_GAP_R  | one idle bus cycle after the read handshake
// ST_WR     | write request outstanding at dst + 4*i with held data
// ST_GAP_W  | one idle bus cycle after the write; decides next word or finish
// ST_FINISH | raises done_o, drops busy_o, returns to idle
module mem_copy_initiator
    import mem_bus_pkg::*;
#(
    parameter int LEN_W          = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [LEN_W-1:0] words_done_o,
    output logic             mem_valid_o,
    input  logic             mem_ready_i,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    output logic [3:0]       mem_wstrb_o,
    input  logic [31:0]      mem_rdata_i
);

    // Timer is loaded with TIMEOUT_CYCLES-1 so valid stays high exactly TIMEOUT_CYCLES cycles.
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    state_e           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [LEN_W-1:0] r_words_done;
    logic [LEN_W-1:0] r_len;
    logic [31:0]      r_rd_ptr;
    logic [31:0]      r_wr_ptr;
    logic [31:0]      r_hold;
    logic             r_valid;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_wstrb;

    logic w_last;
    logic w_tmr_load;
    logic w_tmr_en;
    logic w_expired;

    assign w_last   = (r_words_done == r_len);
    assign w_tmr_en = (r_state == ST_RD) || (r_state == ST_WR);

    // Restart the timeout on every edge that raises valid for a new request.
    always_comb begin
        w_tmr_load = 1'b0;
        case (r_state)
            ST_IDLE:  w_tmr_load = start_i && (len_i != '0);
            ST_GAP_R: w_tmr_load = 1'b1;
            ST_GAP_W: w_tmr_load = !w_last;
            default:  w_tmr_load = 1'b0;
        endcase
    end

    mem_req_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (w_tmr_load),
        .load_val_i(TMR_LOAD),
        .en_i      (w_tmr_en),
        .expired_o (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_words_done <= '0;
            r_len        <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_hold       <= '0;
            r_valid      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= WSTRB_READ;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_rd_ptr     <= word_align(src_addr_i);
                        r_wr_ptr     <= word_align(dst_addr_i);
                        r_len        <= len_i;
                        r_err        <= 1'b0;
                        r_words_done <= '0;
                        r_busy       <= 1'b1;
                        if (len_i == '0) begin
                            r_state <= ST_FINISH;
                        end else begin
                            r_state <= ST_RD;
                            r_valid <= 1'b1;
                            r_addr  <= word_align(src_addr_i);
                            r_wdata <= '0;
                            r_wstrb <= WSTRB_READ;
                        end
                    end
                end
                ST_RD: begin
                    if (mem_ready_i) begin
                        r_hold   <= mem_rdata_i;
                        r_valid  <= 1'b0;
                        r_rd_ptr <= r_rd_ptr + WORD_BYTES;
                        r_state  <= ST_GAP_R;
                    end else if (w_expired) begin
                        r_valid <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= ST_FINISH;
                    end
                end
                ST_GAP_R: begin
                    r_valid <= 1'b1;
                    r_addr  <= r_wr_ptr;
                    r_wdata <= r_hold;
                    r_wstrb <= WSTRB_WORD;
                    r_state <= ST_WR;
                end
                ST_WR: begin
                    if (mem_ready_i) begin
                        r_valid      <= 1'b0;
                        r_wr_ptr     <= r_wr_ptr + WORD_BYTES;
                        r_words_done <= r_words_done + LEN_W'(1);
                        r_state      <= ST_GAP_W;
                    end else if (w_expired) begin
                        r_valid <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= ST_FINISH;
                    end
                end
                ST_GAP_W: begin
                    if (w_last) begin
                        r_state <= ST_FINISH;
                    end else begin
                        r_valid <= 1'b1;
                        r_addr  <= r_rd_ptr;
                        r_wdata <= '0;
                        r_wstrb <= WSTRB_READ;
                        r_state <= ST_RD;
                    end
                end
                ST_FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign err_o        = r_err;
    assign words_done_o = r_words_done;
    assign mem_valid_o  = r_valid;
    assign mem_addr_o   = r_addr;
    assign mem_wdata_o  = r_wdata;
    assign mem_wstrb_o  = r_wstrb;

endmodule
